// File: rtl/sync_edge_filter.sv
// sync_edge_filter
// Consumes an already-synchronized 1-bit signal. Glitches shorter than
// FILTER_LEN cycles are suppressed, a filtered level and one-cycle edge
// pulses are produced, and the selected edges are accumulated into a
// saturating event count. That count is handed downstream over a
// valid/ready channel. Events arriving while the consumer stalls are held
// in a side accumulator, so nothing is lost until that accumulator
// saturates, and the loss is then flagged in the snapshot.
module sync_edge_filter #(
    parameter int FILTER_LEN = 4,   // 1..255
    parameter int CNT_W      = 8,   // 2..16
    parameter int EDGE_SEL   = 0    // 0 rising, 1 falling, 2 both
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_sync,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             evt_ovf
);

    // The stability counter only has to reach FILTER_LEN-1. With
    // FILTER_LEN=1 it never leaves 0, but one bit keeps the vector legal.
    localparam int STAB_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // ------------------------------------------------------------------
    // Filter state
    // ------------------------------------------------------------------
    logic [STAB_W-1:0] stab_q, stab_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Event channel state
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              acc_ovf_q, acc_ovf_d;
    logic              evt_valid_q, evt_valid_d;
    logic [CNT_W-1:0]  evt_count_q, evt_count_d;
    logic              evt_ovf_q, evt_ovf_d;

    // Derived event-channel terms
    logic              ev;
    logic              acc_at_max;
    logic [CNT_W-1:0]  sum;
    logic              sat;
    logic              chan_free;

    // Filter next state: count consecutive disagreeing samples and adopt
    // the new value once it has disagreed for FILTER_LEN edges in a row.
    always_comb begin
        stab_d  = stab_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (d_sync == level_q) begin
            stab_d = '0;
        end else if (stab_q == STAB_LAST) begin
            level_d = d_sync;
            stab_d  = '0;
            rise_d  = d_sync;
            fall_d  = ~d_sync;
        end else begin
            stab_d = stab_q + STAB_W'(1);
        end
    end

    // Edge selection is fixed at elaboration, so only one path is built.
    generate
        if (EDGE_SEL == 0) begin : g_sel_rise
            assign ev = rise_q;
        end else if (EDGE_SEL == 1) begin : g_sel_fall
            assign ev = fall_q;
        end else begin : g_sel_both
            assign ev = rise_q | fall_q;
        end
    endgenerate

    // Saturating add of the current event into the side accumulator. Once
    // the accumulator is at max, any further event sets the lost-event flag.
    always_comb begin
        acc_at_max = (acc_q == CNT_MAX);
        if (ev && acc_at_max) begin
            sum = CNT_MAX;
        end else begin
            sum = acc_q + CNT_W'(ev);
        end
        sat       = acc_ovf_q | (ev & acc_at_max);
        chan_free = ~evt_valid_q | evt_ready;
    end

    // Channel next state: publish the running total whenever the output
    // register is free. Otherwise keep accumulating behind the stalled
    // snapshot. An event arriving on an accept edge is part of sum, so it
    // lands in the new snapshot and is never counted twice.
    always_comb begin
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        evt_valid_d = evt_valid_q;
        evt_count_d = evt_count_q;
        evt_ovf_d   = evt_ovf_q;
        if (chan_free) begin
            if (sum != '0) begin
                evt_count_d = sum;
                evt_ovf_d   = sat;
                evt_valid_d = 1'b1;
                acc_d       = '0;
                acc_ovf_d   = 1'b0;
            end else begin
                evt_valid_d = 1'b0;
            end
        end else begin
            acc_d     = sum;
            acc_ovf_d = sat;
        end
    end

    // Filter registers. An asynchronous reset restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Event channel registers. Reset discards pending and accumulated events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_count_q <= '0;
            evt_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_count_q <= evt_count_d;
            evt_ovf_q   <= evt_ovf_d;
        end
    end

    assign level     = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign evt_valid = evt_valid_q;
    assign evt_count = evt_count_q;
    assign evt_ovf   = evt_ovf_q;

    // Simulation-time sanity properties. Synthesis ignores these.
    a_no_dual_edge : assert property (@(posedge clk) disable iff (!rst_n)
        !(rise && fall));

    a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (evt_valid && !evt_ready) |=>
            (evt_valid && $stable(evt_count) && $stable(evt_ovf)));

endmodule
